dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter sharing the single-port data memory (8-bit word address, 32-bit data, combinational read, write on rising clock edge) between the pipeline MEM stage (port 0) and the test/debug loader (port 1). It grants at most one access per cycle, drives the memory's address, write-enable and write-data inputs, and returns registered read data per port. Contention is resolved by sticky round-robin with a bounded hold, so the pipeline can stream without starving the loader.

## Interface
- N, 32, data width
- ADR_W, 8, address width
- MAX_HOLD, 4, max consecutive grants to one port while the other port is requesting (≥1)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0 / req1  input  1  access request, held with command fields until granted
- we0 / we1  input  1  1 = write, 0 = read
- adr0 / adr1  input  ADR_W  word address
- wdata0 / wdata1  input  N  write data
- gnt0 / gnt1  output  1  combinational grant; access completes in this cycle
- rdata0 / rdata1  output  N  registered read data, holds until the port's next read
- rvalid0 / rvalid1  output  1  one-cycle pulse, cycle after a granted read
- mem_adr  output  ADR_W  to memory address
- mem_write_en  output  1  to memory write enable
- mem_data_in  output  N  to memory write data
- mem_data_out  input  N  from memory read data
- busy  output  1  gnt0 | gnt1

## Operation
- State: owner (1 bit, last granted port), hold_cnt (width clog2(MAX_HOLD+1)), rdata0/1, rvalid0/1.
- Grant decision (combinational, from req0, req1, owner, hold_cnt):
  - neither requests: no grant.
  - only one requests: grant it.
  - both request: grant owner if hold_cnt < MAX_HOLD, else grant the other port.
- At most one of gnt0/gnt1 high; never a grant to a non-requesting port.
- Memory drive: granted port's adr/wdata onto mem_adr/mem_data_in; mem_write_en = granted port's we. With no grant: mem_adr=0, mem_data_in=0, mem_write_en=0.
- On a granted cycle's clock edge:
  - granted port == owner: hold_cnt <= hold_cnt+1, saturating at MAX_HOLD.
  - otherwise: owner <= granted port, hold_cnt <= 1.
  - read: rdata<p> <= mem_data_out; rvalid<p> <= 1.
  - write: memory captures data; no rvalid.
- Cycle with no grant: hold_cnt <= 0, owner unchanged, both rvalid <= 0.
- rvalid of the non-granted port is always 0 next cycle.
- Requester rules: req/we/adr/wdata stable from assertion to the grant cycle inclusive; may re-assert (back-to-back) the next cycle with a new command. Deasserting req before grant is legal (request withdrawn, no side effect).

## Timing
- Reset values: owner=1 (port 0 wins the first tie), hold_cnt=0, rdata0=rdata1=0, rvalid0=rvalid1=0. While rst high: gnt0=gnt1=0, mem_write_en=0, busy=0.
- Grant latency: same cycle as req when uncontended; worst case under contention MAX_HOLD cycles.
- Read latency: rdata valid and rvalid high one cycle after the grant cycle.
- Write latency: memory contents updated at the edge ending the grant cycle; same-port read in the next cycle returns the new value.
- Back-to-back: a port may be granted every cycle; throughput one access/cycle total.
- Reset mid-operation: in-flight rvalid cleared immediately; any write in the reset cycle is suppressed (mem_write_en forced 0).
- hold_cnt saturates; no wrap-around.

## Test plan
- Reset: rst=1 with req0=req1=1 -> gnt0=gnt1=0, mem_write_en=0, rdata0/1=0; release rst with both requesting -> first grant to port 0.
- Uncontended write/read: port 0 writes 32'h0000_00AB to adr 8'd20, next cycle reads adr 20 -> gnt0 both cycles, rdata0=32'h0000_00AB with rvalid0 one cycle after read grant.
- Contention fairness (MAX_HOLD=4): req0 and req1 held high continuously (reads) -> grant pattern 0,0,0,0,1,1,1,1,0,... ; rvalid pulses track grants one cycle later.
- Single streamer: only req1 high for 10 cycles -> gnt1 all 10 cycles (hold limit only applies under contention).
- Withdrawal/idle gap: port 0 granted 3 times, idle cycle, both request -> hold_cnt reset by idle, port 0 granted 4 more before switching.
- Async reset mid-read: assert rst between a granted read and its rvalid cycle -> rvalid stays 0, rdata=0, owner=1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the pipeline MEM
// stage (port 0) and the test/debug loader (port 1). At most one access is
// granted per cycle. Ties go to the current owner, and a port is forced to
// yield after MAX_HOLD consecutive grants while the other port is waiting.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req/we/adr/wdata{0,1}     per-port command, held until granted
//   gnt{0,1}                  combinational grant; access completes this cycle
//   rdata{0,1}, rvalid{0,1}   registered read data and one-cycle valid pulse
//   mem_adr, mem_write_en,
//   mem_data_in               drive to memory
//   mem_data_out              combinational read data from memory
//   busy                      an access is granted this cycle
module dmem_arbiter #(
    parameter int unsigned N        = 32,
    parameter int unsigned ADR_W    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             we0,
    input  logic [ADR_W-1:0] adr0,
    input  logic [N-1:0]     wdata0,
    input  logic             req1,
    input  logic             we1,
    input  logic [ADR_W-1:0] adr1,
    input  logic [N-1:0]     wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [N-1:0]     rdata0,
    output logic [N-1:0]     rdata1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [ADR_W-1:0] mem_adr,
    output logic             mem_write_en,
    output logic [N-1:0]     mem_data_in,
    input  logic [N-1:0]     mem_data_out,
    output logic             busy
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    logic          owner;
    logic [HW-1:0] hold_cnt;
    // Set by reset, cleared by the first grant: the first tie after reset
    // goes to port 0 even though owner resets to 1.
    logic          first;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                if (first) begin
                    gnt0 = 1'b1;
                end else if (hold_cnt < HW'(MAX_HOLD)) begin
                    gnt0 = ~owner;
                    gnt1 = owner;
                end else begin
                    gnt0 = owner;
                    gnt1 = ~owner;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Memory drive from the granted port; zeros when idle.
    always_comb begin
        mem_adr      = '0;
        mem_data_in  = '0;
        mem_write_en = 1'b0;
        if (gnt0) begin
            mem_adr      = adr0;
            mem_data_in  = wdata0;
            mem_write_en = we0;
        end else if (gnt1) begin
            mem_adr      = adr1;
            mem_data_in  = wdata1;
            mem_write_en = we1;
        end
    end

    assign busy = gnt0 | gnt1;

    // Ownership, hold counter and per-port read return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= 1'b1;
            hold_cnt <= '0;
            first    <= 1'b1;
            rdata0   <= '0;
            rdata1   <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) begin
                rdata0 <= mem_data_out;
            end
            if (gnt1 && !we1) begin
                rdata1 <= mem_data_out;
            end
            if (busy) begin
                first <= 1'b0;
                if (gnt1 == owner) begin
                    if (hold_cnt != HW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end else begin
                    owner    <= gnt1;
                    hold_cnt <= HW'(1);
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule
